// File: rtl/pcie_trans_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_trans_pkg
// Purpose  : Shared definitions for the PCIE transaction drain logic.
//            - drain FSM state encoding
//            - source port identifiers
//            - default FIFO word width
// Revision : 1.0  initial release
// ============================================================================
package pcie_trans_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } drain_state_t;

    localparam logic PORT_D0 = 1'b0;
    localparam logic PORT_D1 = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 6;

endpackage
`default_nettype wire

// File: rtl/drain_obuf.sv
`default_nettype none
// ============================================================================
// Module   : drain_obuf
// Purpose  : Two-entry synchronous FIFO holding {port, data} words on their
//            way to the merged output stream.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            push, push_port,
//            push_data        - write one tagged word
//            pop              - remove the head word
//            occ              - number of stored words (0..2)
//            head_valid,
//            head_port,
//            head_data        - head entry (zero after reset)
// Revision : 1.0  initial release
// ============================================================================
module drain_obuf
    import pcie_trans_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  push_port,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic                  head_valid,
    output logic                  head_port,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH:0] r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_occ;
    logic                w_do_pop;
    logic                w_do_push;

    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; the credit logic upstream never violates that.
    assign w_do_pop  = pop & (r_occ != 2'd0);
    assign w_do_push = push & ((r_occ != 2'd2) | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= {push_port, push_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occ        = r_occ;
    assign head_valid = (r_occ != 2'd0);
    assign head_port  = r_mem[r_rd_ptr][DATA_WIDTH];
    assign head_data  = r_mem[r_rd_ptr][DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/pcie_port_drain.sv
`default_nettype none
// ============================================================================
// Module   : pcie_port_drain
// Purpose  : Pops the two PCIE transaction output FIFOs (D0, D1) under
//            weighted round-robin arbitration and merges their words into a
//            single valid/ready stream tagged with the source port.
//            Credit-based flow control against a 2-entry output buffer
//            keeps one word per cycle throughput without losing words.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            enable                - permission to issue new pops
//            empty_d0/1, data_d0/1 - FIFO status and read data (1-cycle)
//            pop_d0/1              - FIFO pop strobes (combinational)
//            out_data, out_port,
//            out_valid, out_ready  - merged output stream
//            cnt_d0/1              - delivered-word counters per port
//            idle                  - FSM is in IDLE
// Config   : PCIE_PORT_DRAIN_COUNTERS_EN - when defined, cnt_d0/cnt_d1 are
//            real counters; otherwise they are tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module pcie_port_drain
    import pcie_trans_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WEIGHT     = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_d0,
    input  logic                  empty_d1,
    input  logic [DATA_WIDTH-1:0] data_d0,
    input  logic [DATA_WIDTH-1:0] data_d1,
    output logic                  pop_d0,
    output logic                  pop_d1,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_port,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  cnt_d0,
    output logic [CNT_WIDTH-1:0]  cnt_d1,
    output logic                  idle
);

    localparam int                 BURST_W     = $clog2(WEIGHT + 1);
    localparam logic [BURST_W-1:0] C_WEIGHT    = BURST_W'(WEIGHT);
    localparam logic [BURST_W-1:0] C_BURST_ONE = BURST_W'(1);

    drain_state_t          r_state;
    logic                  r_grant;
    logic [BURST_W-1:0]    r_burst;
    logic                  r_infl;
    logic                  r_infl_port;

    logic [1:0]            w_occ;
    logic                  w_head_valid;
    logic                  w_head_port;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_deliver;
    logic [2:0]            w_pending;
    logic                  w_credit_ok;
    logic                  w_empty_grant;
    logic                  w_empty_other;
    logic                  w_sel;
    logic                  w_sel_valid;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_push_data;

    // ------------------------------------------------------------------
    // Credits: words buffered + word in flight - word leaving now must
    // stay below the buffer depth for another pop to be safe. occ >= 1
    // whenever w_deliver is set, so the subtraction never underflows.
    // ------------------------------------------------------------------
    assign w_deliver   = w_head_valid & out_ready;
    assign w_pending   = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_deliver};
    assign w_credit_ok = (w_pending < 3'd2);

    // ------------------------------------------------------------------
    // Weighted round-robin port selection
    // ------------------------------------------------------------------
    assign w_empty_grant = (r_grant == PORT_D1) ? empty_d1 : empty_d0;
    assign w_empty_other = (r_grant == PORT_D1) ? empty_d0 : empty_d1;

    always_comb begin
        w_sel       = r_grant;
        w_sel_valid = 1'b0;
        if (!w_empty_grant && (r_burst < C_WEIGHT)) begin
            w_sel_valid = 1'b1;
        end else if (!w_empty_other) begin
            w_sel       = ~r_grant;
            w_sel_valid = 1'b1;
        end else if (!w_empty_grant) begin
            // Burst exhausted but the other port has nothing: keep going.
            w_sel_valid = 1'b1;
        end
    end

    // enable gates pops directly so that no new word is requested in the
    // cycle enable drops, even though the FSM leaves ACTIVE one edge later.
    assign w_pop  = (r_state == ST_ACTIVE) & enable & w_credit_ok & w_sel_valid & ~reset;
    assign pop_d0 = w_pop & (w_sel == PORT_D0) & ~empty_d0;
    assign pop_d1 = w_pop & (w_sel == PORT_D1) & ~empty_d1;

    // ------------------------------------------------------------------
    // FSM, arbitration state and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= PORT_D0;
            r_burst     <= '0;
            r_infl      <= 1'b0;
            r_infl_port <= PORT_D0;
        end else begin
            r_infl <= w_pop;
            if (w_pop) begin
                r_infl_port <= w_sel;
                if (w_sel != r_grant) begin
                    r_grant <= w_sel;
                    r_burst <= C_BURST_ONE;
                end else if (r_burst >= C_WEIGHT) begin
                    // Extra pop on an exhausted burst starts a fresh one.
                    r_burst <= C_BURST_ONE;
                end else begin
                    r_burst <= r_burst + C_BURST_ONE;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable && (!empty_d0 || !empty_d1)) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!enable) begin
                        r_state <= ST_DRAIN;
                    end else if (empty_d0 && empty_d1 && (w_occ == 2'd0) && !r_infl) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if ((w_occ == 2'd0) && !r_infl) begin
                        r_state <= ST_IDLE;
                    end else if (enable) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign idle = (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Output buffer: the word popped last cycle is captured now.
    // ------------------------------------------------------------------
    assign w_push_data = (r_infl_port == PORT_D1) ? data_d1 : data_d0;

    drain_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk        (clk),
        .reset      (reset),
        .push       (r_infl),
        .push_port  (r_infl_port),
        .push_data  (w_push_data),
        .pop        (w_deliver),
        .occ        (w_occ),
        .head_valid (w_head_valid),
        .head_port  (w_head_port),
        .head_data  (w_head_data)
    );

    assign out_valid = w_head_valid;
    assign out_port  = w_head_port;
    assign out_data  = w_head_data;

    // ------------------------------------------------------------------
    // Delivered-word counters
    // ------------------------------------------------------------------
`ifdef PCIE_PORT_DRAIN_COUNTERS_EN
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt_d0;
    logic [CNT_WIDTH-1:0] r_cnt_d1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
        end else if (w_deliver) begin
            if (w_head_port == PORT_D1) begin
                r_cnt_d1 <= r_cnt_d1 + C_CNT_ONE;
            end else begin
                r_cnt_d0 <= r_cnt_d0 + C_CNT_ONE;
            end
        end
    end

    assign cnt_d0 = r_cnt_d0;
    assign cnt_d1 = r_cnt_d1;
`else
    assign cnt_d0 = '0;
    assign cnt_d1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_port_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_port_drain
// Purpose  : Self-checking bench for pcie_port_drain. A FIFO model feeds
//            both ports; every loaded word is queued as an expected output
//            of its port and a separate monitor pops and compares each
//            delivered word. Arbitration, credit and counter rules are
//            checked against a small behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pcie_port_drain;

    localparam int DW     = 6;
    localparam int WEIGHT = 2;
    localparam int CW     = 2;
`ifdef PCIE_PORT_DRAIN_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, out_ready;
    logic          empty_d0, empty_d1;
    logic [DW-1:0] data_d0, data_d1;
    logic          pop_d0, pop_d1, out_port, out_valid, idle;
    logic [DW-1:0] out_data;
    logic [CW-1:0] cnt_d0, cnt_d1;

    pcie_port_drain #(.DATA_WIDTH(DW), .WEIGHT(WEIGHT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .empty_d0(empty_d0), .empty_d1(empty_d1),
        .data_d0(data_d0), .data_d1(data_d1),
        .pop_d0(pop_d0), .pop_d1(pop_d1),
        .out_data(out_data), .out_port(out_port), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    logic [DW-1:0] fq0[$], fq1[$];         // FIFO contents
    logic [DW-1:0] exp_q0[$], exp_q1[$];   // words still owed per port

    // Samples taken at the negedge of the last completed cycle
    logic s_pop0, s_pop1, s_vld, s_rdy, s_port, s_idle, s_rst;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt0, s_cnt1;

    int n_pops = 0;
    int n_deliv = 0;
    int outstanding = 0;
    int run_len = 0;
    logic run_port = 1'b0;
    int m0 = 0, m1 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic load(input int p, input logic [DW-1:0] w);
        if (p == 0) begin
            fq0.push_back(w); exp_q0.push_back(w); empty_d0 = 1'b0;
        end else begin
            fq1.push_back(w); exp_q1.push_back(w); empty_d1 = 1'b0;
        end
    endtask

    // One clock cycle: sample at negedge, then apply FIFO pops after posedge
    task automatic tick();
        logic other_ne;
        @(negedge clk);
        s_pop0 = pop_d0; s_pop1 = pop_d1; s_vld = out_valid; s_rdy = out_ready;
        s_data = out_data; s_port = out_port; s_idle = idle; s_rst = reset;
        s_cnt0 = cnt_d0; s_cnt1 = cnt_d1;
        check("one_pop_per_cycle", {31'd0, s_pop0 & s_pop1}, 0);
        check("pop_while_empty", {30'd0, s_pop1 & empty_d1, s_pop0 & empty_d0}, 0);
        if (s_rst) check("pop_in_reset", {30'd0, s_pop1, s_pop0}, 0);
        if (!s_rst && (s_pop0 || s_pop1)) begin
            // WRR rule: a port may take at most WEIGHT pops in a row while
            // the other port has words; with the other empty, a full burst
            // simply restarts.
            other_ne = s_pop1 ? !empty_d0 : !empty_d1;
            if (run_len > 0 && s_pop1 == run_port) begin
                if (!other_ne && run_len >= WEIGHT) run_len = 1;
                else run_len++;
            end else begin
                run_port = s_pop1;
                run_len  = 1;
            end
            if (other_ne) check("wrr_burst_limit", {31'd0, run_len <= WEIGHT}, 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            // In-flight and buffered words are lost; FIFO contents remain owed.
            exp_q0 = fq0; exp_q1 = fq1;
            outstanding = 0; run_len = 0;
        end else begin
            if (s_pop0 && fq0.size() > 0) data_d0 = fq0.pop_front();
            if (s_pop1 && fq1.size() > 0) data_d1 = fq1.pop_front();
            n_pops += int'(s_pop0) + int'(s_pop1);
            n_deliv += int'(s_vld & s_rdy);
            outstanding += int'(s_pop0) + int'(s_pop1) - int'(s_vld & s_rdy);
            check("outstanding_le_2", {31'd0, outstanding <= 2 && outstanding >= 0}, 1);
        end
        empty_d0 = (fq0.size() == 0);
        empty_d1 = (fq1.size() == 0);
    endtask

    task automatic do_reset(input bit flush);
        if (flush) begin
            fq0.delete(); fq1.delete();
            empty_d0 = 1'b1; empty_d1 = 1'b1;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (k < 300 && !(exp_q0.size() == 0 && exp_q1.size() == 0 && idle === 1'b1)) begin
            tick();
            k++;
        end
        check("drain_completes", {31'd0, k < 300}, 1);
    endtask

    // Monitor: compares every delivered word with the owed words of its port
    always @(negedge clk) begin
        if (mon_on) begin
            check("cnt_d0", {30'd0, cnt_d0}, CNT_EN ? m0 : 0);
            check("cnt_d1", {30'd0, cnt_d1}, CNT_EN ? m1 : 0);
            if (out_valid && out_ready) begin
                if (out_port == 1'b0) begin
                    check("word_owed_d0", {31'd0, exp_q0.size() != 0}, 1);
                    if (exp_q0.size() != 0) check("data_d0", {26'd0, out_data}, {26'd0, exp_q0.pop_front()});
                end else begin
                    check("word_owed_d1", {31'd0, exp_q1.size() != 0}, 1);
                    if (exp_q1.size() != 0) check("data_d1", {26'd0, out_data}, {26'd0, exp_q1.pop_front()});
                end
            end
            if (reset) begin
                m0 = 0; m1 = 0;
            end else if (out_valid && out_ready) begin
                if (out_port) m1 = (m1 + 1) % (1 << CW);
                else          m0 = (m0 + 1) % (1 << CW);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic          exp_order [8];
    logic          pop_port  [8];
    logic          out_ports [8];
    int            pop_cyc   [8];
    int            out_cyc   [8];

    initial begin
        int np, no, k, p0, t_pop, late_pops, d0_before;
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        empty_d0 = 1'b1; empty_d1 = 1'b1; data_d0 = '0; data_d1 = '0;

        // ---- Reset with both FIFOs non-empty ----
        load(0, 6'h2a); load(0, 6'h11); load(1, 6'h07);
        for (int i = 0; i < 3; i++) begin
            tick();
            mon_on = 1'b1;
            check("rst_pop", {30'd0, s_pop1, s_pop0}, 0);
            check("rst_out_valid", {31'd0, s_vld}, 0);
            check("rst_out_data", {26'd0, s_data}, 0);
            check("rst_out_port", {31'd0, s_port}, 0);
            check("rst_cnt", {28'd0, s_cnt1, s_cnt0}, 0);
            check("rst_idle", {31'd0, s_idle}, 1);
        end
        reset = 1'b0;
        drain();

        // ---- Single word 6'h15 on D0 ----
        do_reset(1'b1);
        load(0, 6'h15);
        k = 0;
        do begin tick(); k++; end while (!s_pop0 && !s_pop1 && k < 10);
        check("single_pop_port", {30'd0, s_pop1, s_pop0}, 2'b01);
        tick();
        check("single_valid_c1", {31'd0, s_vld}, 0);
        tick();
        check("single_valid_c2", {31'd0, s_vld}, 1);
        check("single_data", {26'd0, s_data}, 6'h15);
        check("single_port", {31'd0, s_port}, 0);
        drain();
        check("single_cnt_d0", {30'd0, cnt_d0}, CNT_EN ? 1 : 0);
        check("single_idle", {31'd0, idle}, 1);

        // ---- Both ports 4 words: WRR order and full throughput ----
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            load(0, DW'(i)); load(1, DW'(6'h20 + i));
        end
        exp_order = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        np = 0; no = 0; k = 0;
        while ((np < 8 || no < 8) && k < 40) begin
            tick(); k++;
            if ((s_pop0 || s_pop1) && np < 8) begin
                pop_port[np] = s_pop1; pop_cyc[np] = cyc; np++;
            end
            if (s_vld && s_rdy && no < 8) begin
                out_ports[no] = s_port; out_cyc[no] = cyc; no++;
            end
        end
        check("wrr_pop_count", np, 8);
        check("wrr_out_count", no, 8);
        for (int i = 0; i < np; i++) check("wrr_pop_order", {31'd0, pop_port[i]}, {31'd0, exp_order[i]});
        for (int i = 0; i < no; i++) check("wrr_out_order", {31'd0, out_ports[i]}, {31'd0, exp_order[i]});
        if (np == 8) check("wrr_pops_back_to_back", pop_cyc[7] - pop_cyc[0], 7);
        if (no == 8) check("wrr_outs_back_to_back", out_cyc[7] - out_cyc[0], 7);
        drain();

        // ---- Backpressure: out_ready low, 5 words on D0 ----
        do_reset(1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(0, DW'(6'h30 + i));
        p0 = n_pops;
        for (int i = 0; i < 20; i++) tick();
        check("bp_pops_while_stalled", n_pops - p0, 2);
        out_ready = 1'b1;
        tick();
        check("bp_pop_resumes_same_cycle", {31'd0, s_pop0}, 1);
        drain();
        check("bp_total_pops", n_pops - p0, 5);

        // ---- enable drops the cycle after a pop ----
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) load(1, DW'(6'h08 + i));
        p0 = n_pops; d0_before = n_deliv; k = 0;
        do begin tick(); k++; end while (!s_pop1 && k < 10);
        check("en_first_pop", {31'd0, s_pop1}, 1);
        t_pop = cyc;
        enable = 1'b0;
        late_pops = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cyc >= t_pop + 2 && (s_pop0 || s_pop1)) late_pops++;
            if (cyc == t_pop + 2) check("en_not_idle_while_draining", {31'd0, s_idle}, 0);
        end
        check("en_no_pops_after_drop", late_pops, 0);
        check("en_idle_after_drain", {31'd0, idle}, 1);
        check("en_popped_words_delivered", n_deliv - d0_before, n_pops - p0);
        enable = 1'b1;
        drain();

        // ---- Counter wrap: 5 D0 words ----
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) load(0, DW'(6'h3a + i));
        drain();
        check("cnt_wrap_d0", {30'd0, cnt_d0}, CNT_EN ? 1 : 0);
        check("cnt_wrap_d1", {30'd0, cnt_d1}, 0);

        // ---- Randomized traffic with one mid-run reset ----
        do_reset(1'b1);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (fq0.size() < 6) load(0, DW'($urandom));
                end else begin
                    if (fq1.size() < 6) load(1, DW'($urandom));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 15) != 0);
            if (i == 400) do_reset(1'b0);
            else tick();
        end
        enable = 1'b1; out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
